// File: rtl/t1_sim_ctrl_pkg.sv
// Shared types and constants for the simulation run controller.
// Holds the 3-bit FSM state encoding, the status codes reported on the status
// port, and the default counter width and drain length.
package t1_sim_ctrl_pkg;

  localparam int DEF_CNT_W        = 64;
  localparam int DEF_DRAIN_CYCLES = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RUN   = 3'd1,
    ST_DRAIN = 3'd2,
    ST_PASS  = 3'd3,
    ST_FAIL  = 3'd4
  } state_e;

  localparam logic [7:0] STATUS_RUN       = 8'd0;
  localparam logic [7:0] STATUS_RETIRE_TO = 8'd1;
  localparam logic [7:0] STATUS_GLOBAL_TO = 8'd2;
  localparam logic [7:0] STATUS_PASS      = 8'd255;

endpackage

// File: rtl/t1_sim_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats enable).
// Latency: value updates on the rising edge after clr_i/en_i; no backpressure.
// Ports: clk_i, rst_i (async active-high), clr_i, en_i, cnt_o (W bits).
module t1_sim_sat_counter
  import t1_sim_ctrl_pkg::*;
#(
  parameter int W = DEF_CNT_W
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         clr_i,
  input  logic         en_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/t1_sim_ctrl.sv
// Simulation run controller: IDLE->RUN on cfg, watches retire/global timeouts,
// waits for both completion pulses, drains DRAIN_CYCLES clocks, then PASS/FAIL.
// Latency: state/status visible one cycle after the deciding edge; no backpressure.
// Ports: clock, reset (async active-high); cfg_valid + cfg_* (latched in IDLE);
//   retire_valid, done_dpi, done_tb; outputs dump_enable, status, cycle, state.
module t1_sim_ctrl
  import t1_sim_ctrl_pkg::*;
#(
  parameter int CNT_W        = DEF_CNT_W,
  parameter int DRAIN_CYCLES = DEF_DRAIN_CYCLES
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic [CNT_W-1:0] cfg_global_timeout,
  input  logic [CNT_W-1:0] cfg_dump_start,
  input  logic [CNT_W-1:0] cfg_dump_end,
  input  logic             retire_valid,
  input  logic             done_dpi,
  input  logic             done_tb,
  output logic             dump_enable,
  output logic [7:0]       status,
  output logic [CNT_W-1:0] cycle,
  output logic [2:0]       state
);

  state_e           state_q, state_d;
  logic [7:0]       status_q, status_d;
  logic [CNT_W-1:0] timeout_q, global_q, dump_start_q, dump_end_q;
  logic             dpi_seen_q, tb_seen_q;

  logic [CNT_W-1:0] cycle_cnt, since_cnt, drain_cnt;
  logic             start, active, in_run, in_drain;
  logic             global_hit, retire_hit, both_done, drain_last;

  assign in_run   = (state_q == ST_RUN);
  assign in_drain = (state_q == ST_DRAIN);
  assign active   = in_run || in_drain;
  assign start    = (state_q == ST_IDLE) && cfg_valid;

  assign global_hit = (global_q != '0) && (cycle_cnt == global_q);
  // A retire in the same cycle as the deadline rescues the run.
  assign retire_hit = (timeout_q != '0) && (since_cnt == timeout_q) && !retire_valid;
  // Either completion may arrive first; the current pulse counts as seen.
  assign both_done  = (dpi_seen_q || done_dpi) && (tb_seen_q || done_tb);
  assign drain_last = (drain_cnt == CNT_W'(DRAIN_CYCLES - 1));

  always_comb begin
    state_d  = state_q;
    status_d = status_q;
    unique case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          state_d  = ST_RUN;
          status_d = STATUS_RUN;
        end
      end
      ST_RUN: begin
        // Failures outrank completion; global outranks retire timeout.
        if (global_hit) begin
          state_d  = ST_FAIL;
          status_d = STATUS_GLOBAL_TO;
        end else if (retire_hit) begin
          state_d  = ST_FAIL;
          status_d = STATUS_RETIRE_TO;
        end else if (both_done) begin
          state_d  = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (global_hit) begin
          state_d  = ST_FAIL;
          status_d = STATUS_GLOBAL_TO;
        end else if (drain_last) begin
          state_d  = ST_PASS;
          status_d = STATUS_PASS;
        end
      end
      default: begin
        state_d  = state_q;
        status_d = status_q;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      status_q     <= STATUS_RUN;
      timeout_q    <= '0;
      global_q     <= '0;
      dump_start_q <= '0;
      dump_end_q   <= '0;
      dpi_seen_q   <= 1'b0;
      tb_seen_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      status_q <= status_d;
      if (start) begin
        timeout_q    <= cfg_timeout;
        global_q     <= cfg_global_timeout;
        dump_start_q <= cfg_dump_start;
        dump_end_q   <= cfg_dump_end;
        dpi_seen_q   <= 1'b0;
        tb_seen_q    <= 1'b0;
      end else if (in_run) begin
        if (done_dpi) dpi_seen_q <= 1'b1;
        if (done_tb)  tb_seen_q  <= 1'b1;
      end
    end
  end

  // The edge that enters FAIL does not advance cycle, so it freezes at the
  // value that tripped the global timeout.
  t1_sim_sat_counter #(.W(CNT_W)) u_cycle_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (start),
    .en_i  (active && (state_d != ST_FAIL)),
    .cnt_o (cycle_cnt)
  );

  t1_sim_sat_counter #(.W(CNT_W)) u_since_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (start || (in_run && retire_valid)),
    .en_i  (in_run),
    .cnt_o (since_cnt)
  );

  // Held at zero outside DRAIN so each DRAIN entry starts a fresh count.
  t1_sim_sat_counter #(.W(CNT_W)) u_drain_cnt (
    .clk_i (clock),
    .rst_i (reset),
    .clr_i (!in_drain),
    .en_i  (in_drain),
    .cnt_o (drain_cnt)
  );

  assign dump_enable = active && (cycle_cnt >= dump_start_q) &&
                       ((dump_end_q == '0) || (cycle_cnt < dump_end_q));
  assign status = status_q;
  assign cycle  = cycle_cnt;
  assign state  = state_q;

endmodule

// File: doc/t1_sim_ctrl.md
T1_SIM_CTRL -- requirements
Module: t1_sim_ctrl

Interface
REQ-001 Parameters SHALL be: CNT_W, 64, width of all cycle counters and timeout fields; DRAIN_CYCLES, 16, cycles held in DRAIN before PASS.
REQ-002 Port SHALL exist: clock  input  1  sole clock, all state on rising edge.
REQ-003 Port SHALL exist: reset  input  1  asynchronous, active-high reset.
REQ-004 Port SHALL exist: cfg_valid  input  1  one-cycle strobe that latches all cfg_* fields; accepted only in IDLE.
REQ-005 Port SHALL exist: cfg_timeout  input  CNT_W  maximum cycles between retires; 0 disables.
REQ-006 Port SHALL exist: cfg_global_timeout  input  CNT_W  maximum run cycles; 0 disables.
REQ-007 Port SHALL exist: cfg_dump_start / cfg_dump_end  input  CNT_W each  wave dump window; dump_end 0 = never ends.
REQ-008 Port SHALL exist: retire_valid  input  1  vector instruction retired this cycle.
REQ-009 Port SHALL exist: done_dpi, done_tb  input  1 each  completion pulses from DPI side and testbench side.
REQ-010 Port SHALL exist: dump_enable  output  1  wave dump window active.
REQ-011 Port SHALL exist: status  output  8  0 running/idle, 255 pass, 1 retire timeout, 2 global timeout.
REQ-012 Port SHALL exist: cycle  output  CNT_W  run-cycle count; state  output  3  current FSM state.

Function
REQ-013 FSM states SHALL be IDLE, RUN, DRAIN, PASS, FAIL; PASS and FAIL terminal until reset.
REQ-014 IDLE->RUN on cfg_valid; cfg fields latched the same edge; cfg_valid outside IDLE ignored.
REQ-015 cycle SHALL clear to 0 on IDLE->RUN, increment by 1 each clock in RUN/DRAIN, saturate at all-ones, freeze in PASS/FAIL.
REQ-016 since_retire counter SHALL clear on IDLE->RUN and on any retire_valid cycle, else increment in RUN; saturates.
REQ-017 RUN->FAIL, status 1, when cfg_timeout!=0, since_retire==cfg_timeout and retire_valid low that cycle (retire wins the tie).
REQ-018 RUN or DRAIN->FAIL, status 2, when cfg_global_timeout!=0 and cycle==cfg_global_timeout; global outranks retire timeout in the same cycle.
REQ-019 done_dpi and done_tb SHALL each set a sticky flag; RUN->DRAIN on the first edge both flags (or current pulses) are set, order and cycle separation arbitrary.
REQ-020 Fail condition and completion in the same cycle: FAIL wins.
REQ-021 DRAIN SHALL count DRAIN_CYCLES clocks, then ->PASS, status 255; retire timeout not checked in DRAIN.
REQ-022 status, state registered: visible the cycle after the triggering edge; status holds its code in terminal states.
REQ-023 dump_enable SHALL be high in RUN/DRAIN when cycle>=cfg_dump_start and (cfg_dump_end==0 or cycle<cfg_dump_end); low in IDLE/PASS/FAIL.
REQ-024 cfg_dump_end!=0 and <=cfg_dump_start: dump_enable never asserts.
REQ-025 Inputs retire_valid/done_* in IDLE, PASS, FAIL SHALL be ignored (sticky flags not set).

Reset
REQ-026 Assertion of reset SHALL immediately force IDLE, status 0, cycle 0, dump_enable 0, all counters, sticky flags and latched cfg to 0, regardless of state.
REQ-027 Deassertion SHALL be synchronous-safe: first state change no earlier than the first rising edge after release.

Structure
REQ-028 Package t1_sim_ctrl_pkg SHALL hold the state enum (3-bit), status codes (STATUS_RUN=0, STATUS_RETIRE_TO=1, STATUS_GLOBAL_TO=2, STATUS_PASS=255) and default CNT_W.
REQ-029 One sub-module t1_sim_sat_counter (clear, enable, saturate, CNT_W wide) SHALL implement cycle, since_retire and drain counters.

Verification
REQ-030 cfg_timeout=100, retire every 50 cycles, done_dpi@cycle 400, done_tb@cycle 410 -> DRAIN at 410, status 255 after 16 more cycles.
REQ-031 cfg_timeout=100, no retire -> status 1 the cycle after since_retire reaches 100; retire exactly on cycle 100 -> stays RUN.
REQ-032 cfg_global_timeout=200 and cfg_timeout=200, no retire -> status 2 (global wins); cycle frozen at 200.
REQ-033 cfg_dump_start=10, cfg_dump_end=20 -> dump_enable high for cycle 10..19 only; start=0,end=0 -> high throughout RUN/DRAIN.
REQ-034 reset asserted mid-DRAIN and mid-FAIL -> outputs zero asynchronously; new cfg_valid restarts with cycle 0.
REQ-035 done_dpi and done_tb in same cycle as retire timeout -> FAIL status 1, no DRAIN.
